// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic bad;
        case (size)
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo[1:0] != 2'b00);
            SZ_D:    bad = (addr_lo != 3'b000);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane mask, store-data shift and load extract/extend for one access.
module lsu_lane_align #(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off_i,
    input  logic [1:0]                size_i,
    input  logic                      unsigned_i,
    input  logic [XLEN-1:0]           wdata_i,
    input  logic [XLEN-1:0]           rdata_i,
    output logic [XLEN/8-1:0]         mask_o,
    output logic [XLEN-1:0]           wdata_o,
    output logic [XLEN-1:0]           rdata_o
);

    localparam int MW = XLEN / 8;

    logic [3:0]      nbytes;
    logic [15:0]     run;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] shr;
    logic            sign;

    always_comb begin
        nbytes  = 4'd1 << size_i;
        run     = (16'd1 << nbytes) - 16'd1;
        mask_o  = MW'(run << off_i);
        shr     = rdata_i >> {off_i, 3'b000};
        keep    = '0;
        sign    = 1'b0;
        rdata_o = '0;
        // keep covers the access width; sign is the top bit of the extracted field
        for (int i = 0; i < XLEN; i++) begin
            keep[i] = (i < 8 * int'(nbytes));
            if (i == 8 * int'(nbytes) - 1) sign = shr[i];
        end
        for (int i = 0; i < XLEN; i++) begin
            rdata_o[i] = keep[i] ? shr[i] : (sign & ~unsigned_i);
        end
        wdata_o = (wdata_i & keep) << {off_i, 3'b000};
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit with valid/ready handshakes to the pipeline and
// to a variable-latency data memory, including misalignment and timeout traps.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    output logic              o_rsp_valid,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_trap,
    output logic              o_rsp_timeout,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_mask,
    input  logic              i_mem_ready,
    input  logic              i_mem_valid,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    localparam int MW = XLEN / 8;
    localparam int OW = $clog2(MW);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [1:0]      size_q, size_d;
    logic            wen_q, wen_d;
    logic            uns_q, uns_d;
    logic            trap_q, trap_d;
    logic            tmo_q, tmo_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [MW-1:0]   lane_mask;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_rdata;
    logic            bad;
    logic            in_req;
    logic            in_rsp;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .off_i      (addr_q[OW-1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (i_mem_rdata),
        .mask_o     (lane_mask),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata)
    );

    assign bad = misaligned(i_req_size, i_req_addr[2:0]) || (XLEN == 32 && i_req_size == SZ_D);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            trap_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            wen_q   <= wen_d;
            uns_q   <= uns_d;
            trap_q  <= trap_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        wen_d   = wen_q;
        uns_d   = uns_q;
        trap_d  = trap_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    size_d  = i_req_size;
                    wen_d   = i_req_wen;
                    uns_d   = i_req_unsigned;
                    trap_d  = bad;
                    tmo_d   = 1'b0;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = bad ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_mem_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a completion in the timeout cycle still wins over the timeout
                if (i_mem_valid) begin
                    rdata_d = wen_q ? '0 : lane_rdata;
                    state_d = ST_RESP;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_req = (state_q == ST_REQ);
    assign in_rsp = (state_q == ST_RESP);

    assign o_req_ready   = (state_q == ST_IDLE);
    assign o_mem_ren     = in_req & ~wen_q;
    assign o_mem_wen     = in_req & wen_q;
    assign o_mem_addr    = in_req ? {addr_q[XLEN-1:OW], {OW{1'b0}}} : '0;
    assign o_mem_mask    = in_req ? lane_mask : '0;
    assign o_mem_wdata   = (in_req & wen_q) ? lane_wdata : '0;
    assign o_rsp_valid   = in_rsp;
    assign o_rsp_rdata   = in_rsp ? rdata_q : '0;
    assign o_rsp_trap    = in_rsp & trap_q;
    assign o_rsp_timeout = in_rsp & tmo_q;

endmodule
